// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: oversampled asynchronous serial receiver.
// Mid-bit sampling of start, data (LSB first), optional parity and 1..2 stop
// bits. Each word is handed off through a single valid/ready output register
// together with its parity/framing status. A sticky overrun flag records
// frames that were lost while that register was full.
module serial_frame_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    // Cycle counter runs down to zero; zero marks the sample point.
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic [2:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_perr_out;
    logic                  r_ferr_out;
    logic                  r_ovr;

    logic w_s;
    logic w_fall;
    logic w_tick;
    logic w_done;
    logic w_ferr_now;
    logic w_hs;
    logic w_load;

    assign w_s        = r_sync2;
    assign w_fall     = r_prev & ~w_s;
    assign w_tick     = (r_cnt == '0);
    // Last stop sample of the frame: the output stage acts in this cycle.
    assign w_done     = (r_state == S_STOP) & w_tick & (r_bcnt == LAST_STOP);
    // Framing status including the stop sample being taken right now.
    assign w_ferr_now = r_ferr | ~w_s;
    assign w_hs       = r_valid & out_ready;
    assign w_load     = w_done & (~r_valid | w_hs);

    // Two-flop synchroniser plus delayed copy for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Frame FSM: start qualification, data shift, parity and stop-bit checks.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Only a fresh falling edge arms a frame; a held-low line never does.
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_cnt   <= FULL_M1;
                        r_bcnt  <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                        // High at mid-start means a glitch: drop it silently.
                        r_state <= w_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_s, r_shift[DATA_WIDTH-1:1]};
                        r_cnt   <= FULL_M1;
                        if (r_bcnt == LAST_DATA) begin
                            r_bcnt  <= '0;
                            r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_perr  <= (^r_shift) ^ w_s ^ ODD_PAR;
                        r_cnt   <= FULL_M1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_ferr <= w_ferr_now;
                        if (r_bcnt == LAST_STOP) begin
                            r_bcnt  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                            r_cnt  <= FULL_M1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register: load on empty or same-cycle handshake, otherwise drop and flag overrun.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_data     <= r_shift;
                r_perr_out <= r_perr;
                r_ferr_out <= w_ferr_now;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            // Set beats clear when a drop and a handshake coincide.
            if (w_done & r_valid & ~out_ready) begin
                r_ovr <= 1'b1;
            end else if (w_hs) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign parity_err = r_perr_out;
    assign frame_err  = r_ferr_out;
    assign overrun    = r_ovr;
    assign busy       = (r_state != S_IDLE);

endmodule
